// File: rtl/mmio_hub_pkg.sv
// rtl/mmio_hub_pkg.sv - register offsets and sizing helper shared by the mmio_hub slice
package mmio_hub_pkg;

    localparam logic [7:0] OFF_SW        = 8'h00;
    localparam logic [7:0] OFF_LED       = 8'h40;
    localparam logic [7:0] OFF_BLINK_EN  = 8'h80;
    localparam logic [7:0] OFF_BLINK_PER = 8'h84;
    localparam logic [7:0] OFF_STATUS    = 8'h88;
    localparam logic [7:0] OFF_IRQ_EN    = 8'h8C;

    // Switch and LED banks each own a 16-word window selected by the top two offset bits.
    localparam logic [7:0] REGION_MASK   = 8'hC0;

    // Bits needed to hold a counter that runs 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - one 16-bit switch bank: 2-FF synchroniser, stability counter, accepted value
module sw_debounce
    import mmio_hub_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] raw,
    output logic [15:0] stable,
    output logic        change
);

    localparam int            CW       = clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [15:0]   sync_a;
    logic [15:0]   sync_b;
    logic [15:0]   sync_prev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] run;

    // A new synchronised value restarts the run at zero in the same cycle it is first seen.
    always_comb begin
        run = (sync_b == sync_prev) ? cnt : '0;
    end

    assign change = (sync_b != stable) && (run == CNT_LAST);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync_a    <= '0;
            sync_b    <= '0;
            sync_prev <= '0;
            stable    <= '0;
            cnt       <= '0;
        end else begin
            sync_a    <= raw;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (change) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= run + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_hub.sv
// rtl/mmio_hub.sv - memory-mapped IO hub: debounced switch banks, blinking LED banks, change interrupt
module mmio_hub
    import mmio_hub_pkg::*;
#(
    parameter int          SW_BANKS      = 2,
    parameter int          LED_BANKS     = 2,
    parameter int          DEBOUNCE_CYC  = 20000,
    parameter logic [23:0] BLINK_DEFAULT = 24'd5000000
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   io_read,
    input  logic                   io_write,
    input  logic [7:0]             io_addr,
    input  logic [31:0]            io_wdata,
    output logic [31:0]            io_rdata,
    output logic                   io_ready,
    input  logic [16*SW_BANKS-1:0] switches,
    output logic [16*LED_BANKS-1:0] lights,
    output logic                   irq
);

    logic [15:0]          sw_deb [SW_BANKS];
    logic [SW_BANKS-1:0]  sw_change;
    logic [SW_BANKS-1:0]  sw_status;
    logic [SW_BANKS-1:0]  irq_en;
    logic [SW_BANKS-1:0]  status_clr;
    logic [15:0]          led_reg [LED_BANKS];
    logic [LED_BANKS-1:0] blink_en;
    logic [23:0]          blink_per;
    logic [23:0]          blink_cnt;
    logic                 phase;

    logic        wr;
    logic        rd;
    logic [7:0]  off;
    logic [3:0]  idx;
    logic        in_sw;
    logic        in_led;
    logic        blink_wr;
    logic [31:0] rd_mux;
    logic        unused_bits;

    for (genvar i = 0; i < SW_BANKS; i++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clock (clock),
            .rst   (rst),
            .raw   (switches[16*i +: 16]),
            .stable(sw_deb[i]),
            .change(sw_change[i])
        );
    end

    // A simultaneous read and write strobe is treated purely as a write.
    assign wr       = io_write;
    assign rd       = io_read & ~io_write;
    assign off      = {io_addr[7:2], 2'b00};
    assign idx      = io_addr[5:2];
    assign in_sw    = (off & REGION_MASK) == OFF_SW;
    assign in_led   = (off & REGION_MASK) == OFF_LED;
    assign blink_wr = wr && (off == OFF_BLINK_PER);

    assign status_clr  = (wr && (off == OFF_STATUS)) ? io_wdata[SW_BANKS-1:0] : '0;
    assign unused_bits = ^{io_addr[1:0], io_wdata[31:24]};

    always_comb begin
        rd_mux = '0;
        if (in_sw) begin
            for (int i = 0; i < SW_BANKS; i++) begin
                if (idx == 4'(i)) begin
                    rd_mux = {16'h0, sw_deb[i]};
                end
            end
        end else if (in_led) begin
            for (int j = 0; j < LED_BANKS; j++) begin
                if (idx == 4'(j)) begin
                    rd_mux = {16'h0, led_reg[j]};
                end
            end
        end else begin
            case (off)
                OFF_BLINK_EN:  rd_mux = 32'(blink_en);
                OFF_BLINK_PER: rd_mux = {8'h0, blink_per};
                OFF_STATUS:    rd_mux = 32'(sw_status);
                OFF_IRQ_EN:    rd_mux = 32'(irq_en);
                default:       rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < LED_BANKS; j++) begin
                led_reg[j] <= '0;
            end
            blink_en  <= '0;
            blink_per <= BLINK_DEFAULT;
            irq_en    <= '0;
            sw_status <= '0;
            irq       <= 1'b0;
            io_ready  <= 1'b0;
            io_rdata  <= '0;
        end else begin
            io_ready <= io_read | io_write;
            io_rdata <= rd ? rd_mux : 32'h0;
            irq      <= |(sw_status & irq_en);
            // A new change event outranks a same-cycle write-one-to-clear of that bit.
            sw_status <= (sw_status & ~status_clr) | sw_change;
            if (wr) begin
                if (in_led) begin
                    for (int j = 0; j < LED_BANKS; j++) begin
                        if (idx == 4'(j)) begin
                            led_reg[j] <= io_wdata[15:0];
                        end
                    end
                end
                case (off)
                    OFF_BLINK_EN:  blink_en  <= io_wdata[LED_BANKS-1:0];
                    OFF_BLINK_PER: blink_per <= io_wdata[23:0];
                    OFF_IRQ_EN:    irq_en    <= io_wdata[SW_BANKS-1:0];
                    default:       ;
                endcase
            end
        end
    end

    // Zero half-period means solid on; reprogramming the period restarts in the on phase.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_wr) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_per == 24'd0) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == blink_per - 24'd1) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            lights <= '0;
        end else begin
            for (int j = 0; j < LED_BANKS; j++) begin
                lights[16*j +: 16] <= (blink_en[j] && !phase) ? 16'h0 : led_reg[j];
            end
        end
    end

endmodule

// File: tb/tb_mmio_hub.sv
// tb/tb_mmio_hub.sv - self-checking bench for mmio_hub against a behavioural register/switch/blink model
module tb_mmio_hub;

    localparam int          SW_BANKS  = 2;
    localparam int          LED_BANKS = 2;
    localparam int          DEB       = 4;
    localparam logic [23:0] BLINK_DEF = 24'd3;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        io_read = 1'b0;
    logic        io_write = 1'b0;
    logic [7:0]  io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        io_ready;
    logic [31:0] switches = '0;
    logic [31:0] lights;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mmio_hub #(
        .SW_BANKS     (SW_BANKS),
        .LED_BANKS    (LED_BANKS),
        .DEBOUNCE_CYC (DEB),
        .BLINK_DEFAULT(BLINK_DEF)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .io_read (io_read),
        .io_write(io_write),
        .io_addr (io_addr),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .io_ready(io_ready),
        .switches(switches),
        .lights  (lights),
        .irq     (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register state plus a history of raw switch samples.
    logic [15:0] m_led [LED_BANKS];
    logic [1:0]  m_ben;
    logic [23:0] m_per;
    logic [1:0]  m_status;
    logic [1:0]  m_irq_en;
    logic [15:0] m_deb [SW_BANKS];
    logic [31:0] hist [$];
    int          ep_k;
    bit          ep_ph;
    bit          model_on = 0;

    logic        e_ready;
    logic [31:0] e_rdata;
    logic [31:0] e_lights;
    logic        e_irq;

    logic [31:0] t_rdv;
    logic [1:0]  t_chg;
    logic [1:0]  t_clr;
    logic        t_ph;
    logic [15:0] t_v;
    bit          t_all;
    int          t_n;
    logic [7:0]  t_w;

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [7:0] w;
        int id;
        w = a & 8'hFC;
        if (w < 8'h40) begin
            id = int'(w) / 4;
            if (id < SW_BANKS) return {16'h0, m_deb[id]};
            return 32'h0;
        end
        if (w < 8'h80) begin
            id = (int'(w) - 'h40) / 4;
            if (id < LED_BANKS) return {16'h0, m_led[id]};
            return 32'h0;
        end
        case (w)
            8'h80:   return {30'h0, m_ben};
            8'h84:   return {8'h0, m_per};
            8'h88:   return {30'h0, m_status};
            8'h8C:   return {30'h0, m_irq_en};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_phase();
        if (m_per == 24'd0) return 1'b1;
        return ep_ph ^ (((ep_k / int'(m_per)) % 2) == 1);
    endfunction

    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < LED_BANKS; j++) m_led[j] = '0;
            for (int i = 0; i < SW_BANKS; i++) m_deb[i] = '0;
            m_ben = '0; m_per = BLINK_DEF; m_status = '0; m_irq_en = '0;
            ep_k = 0; ep_ph = 1'b0;
            hist = {};
            for (int k = 0; k < 8; k++) hist.push_back(32'h0);
            e_ready = 1'b0; e_rdata = '0; e_lights = '0; e_irq = 1'b0;
            model_on = 1;
        end else begin
            t_ph = model_phase();
            t_rdv = model_read(io_addr);
            e_ready = io_read | io_write;
            e_rdata = (io_read && !io_write) ? t_rdv : 32'h0;
            e_irq = |(m_status & m_irq_en);
            for (int j = 0; j < LED_BANKS; j++)
                e_lights[16*j +: 16] = (m_ben[j] && !t_ph) ? 16'h0 : m_led[j];
            // The synchroniser presents the raw value sampled two edges earlier.
            hist.push_back(switches);
            if (hist.size() > 16) void'(hist.pop_front());
            t_n = hist.size();
            for (int i = 0; i < SW_BANKS; i++) begin
                t_chg[i] = 1'b0;
                t_v = hist[t_n-3][16*i +: 16];
                t_all = 1;
                for (int k = 0; k < DEB; k++)
                    if (hist[t_n-3-k][16*i +: 16] != t_v) t_all = 0;
                if (t_all && t_v != m_deb[i]) begin
                    t_chg[i] = 1'b1;
                    m_deb[i] = t_v;
                end
            end
            t_w = io_addr & 8'hFC;
            t_clr = (io_write && t_w == 8'h88) ? io_wdata[1:0] : 2'b00;
            m_status = (m_status & ~t_clr) | t_chg;
            if (io_write && t_w == 8'h84) begin
                m_per = io_wdata[23:0];
                ep_k = 0;
                ep_ph = 1'b1;
            end else begin
                ep_k++;
            end
            if (io_write) begin
                if (t_w == 8'h40) m_led[0] = io_wdata[15:0];
                if (t_w == 8'h44) m_led[1] = io_wdata[15:0];
                if (t_w == 8'h80) m_ben = io_wdata[1:0];
                if (t_w == 8'h8C) m_irq_en = io_wdata[1:0];
            end
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            check("cyc_io_ready", {31'h0, io_ready}, {31'h0, e_ready});
            check("cyc_io_rdata", io_rdata, e_rdata);
            check("cyc_lights", lights, e_lights);
            check("cyc_irq", {31'h0, irq}, {31'h0, e_irq});
        end
    end

    task automatic bus(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] q, output logic rdy);
        io_read = rd; io_write = wr; io_addr = a; io_wdata = d;
        @(posedge clock); #1;
        io_read = 1'b0; io_write = 1'b0;
        q = io_rdata; rdy = io_ready;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    logic [31:0] q;
    logic        rdy;
    logic [15:0] sw_vals [4] = '{16'h0000, 16'h00F0, 16'h0F0F, 16'hFFFF};
    logic [7:0]  addrs [11] = '{8'h00, 8'h04, 8'h08, 8'h40, 8'h44, 8'h48,
                                8'h80, 8'h84, 8'h88, 8'h8C, 8'hFC};
    logic [15:0] blink_exp [7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};

    initial begin
        #1 rst = 1'b0;
        // Reset held with random inputs.
        repeat (5) begin
            @(posedge clock); #1;
            switches = $urandom; io_read = 1'($urandom); io_write = 1'($urandom);
            io_addr = 8'($urandom); io_wdata = $urandom;
            check("rst_lights", lights, 32'h0);
            check("rst_irq", {31'h0, irq}, 32'h0);
            check("rst_ready", {31'h0, io_ready}, 32'h0);
        end
        switches = '0; io_read = 1'b0; io_write = 1'b0;
        @(posedge clock); #1;
        rst = 1'b1;
        idle(1);
        bus(1, 0, 8'h84, 0, q, rdy);
        check("rst_blink_per", q, 32'd3);
        check("rst_blink_ready", {31'h0, rdy}, 32'h1);

        // LED write/read.
        bus(0, 1, 8'h40, 32'h1234ABCD, q, rdy);
        check("led_wr_ready", {31'h0, rdy}, 32'h1);
        bus(1, 0, 8'h40, 0, q, rdy);
        check("led_rd_data", q, 32'h0000ABCD);
        check("led_rd_ready", {31'h0, rdy}, 32'h1);
        check("led_lights", {16'h0, lights[15:0]}, 32'h0000ABCD);

        // Switch bank 1 with a glitch, then stable.
        bus(0, 1, 8'h8C, 32'h2, q, rdy);
        switches = 32'h00F0_0000; idle(1);
        switches = 32'h0; idle(2);
        switches = 32'h00F0_0000;
        idle(5);
        bus(1, 0, 8'h04, 0, q, rdy);
        check("deb_before", q, 32'h0);
        check("irq_before", {31'h0, irq}, 32'h0);
        bus(1, 0, 8'h04, 0, q, rdy);
        check("deb_after", q, 32'h000000F0);
        check("irq_set", {31'h0, irq}, 32'h1);
        bus(1, 0, 8'h88, 0, q, rdy);
        check("status_rd", q, 32'h2);
        bus(0, 1, 8'h88, 32'h2, q, rdy);
        check("irq_hold", {31'h0, irq}, 32'h1);
        idle(1);
        check("irq_clear", {31'h0, irq}, 32'h0);

        // Blink on bank 0.
        bus(0, 1, 8'h80, 32'h1, q, rdy);
        bus(0, 1, 8'h40, 32'hFFFF, q, rdy);
        bus(0, 1, 8'h84, 32'd3, q, rdy);
        for (int k = 0; k < 7; k++) begin
            idle(1);
            check("blink_seq", {16'h0, lights[15:0]}, {16'h0, blink_exp[k]});
        end
        bus(0, 1, 8'h84, 32'd0, q, rdy);
        for (int k = 0; k < 6; k++) begin
            idle(1);
            check("blink_solid", {16'h0, lights[15:0]}, 32'h0000FFFF);
        end

        // Set and clear of the same status bit in one cycle.
        bus(0, 1, 8'h88, 32'h3, q, rdy);
        switches = 32'h00F0_0F0F;
        idle(5);
        bus(0, 1, 8'h88, 32'h1, q, rdy);
        bus(1, 0, 8'h88, 0, q, rdy);
        check("set_wins", q, 32'h1);
        bus(1, 0, 8'hFC, 0, q, rdy);
        check("unmapped_data", q, 32'h0);
        check("unmapped_ready", {31'h0, rdy}, 32'h1);
        bus(1, 1, 8'h8C, 32'h3, q, rdy);
        check("rdwr_data", q, 32'h0);
        check("rdwr_ready", {31'h0, rdy}, 32'h1);
        bus(1, 0, 8'h8C, 0, q, rdy);
        check("rdwr_applied", q, 32'h3);
        idle(2);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        check("pre_rst_lights", {16'h0, lights[15:0]}, 32'h0000FFFF);

        // Reset in the middle of an access and a debounce run.
        switches = 32'h1234_0F0F;
        idle(2);
        io_read = 1'b1; io_addr = 8'h84;
        #3 rst = 1'b0;
        #1;
        check("async_lights", lights, 32'h0);
        check("async_irq", {31'h0, irq}, 32'h0);
        check("async_ready", {31'h0, io_ready}, 32'h0);
        @(posedge clock); #1;
        io_read = 1'b0;
        check("abort_ready", {31'h0, io_ready}, 32'h0);
        idle(2);
        rst = 1'b1;
        idle(1);
        check("post_rst_ready", {31'h0, io_ready}, 32'h0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                int bank;
                bank = $urandom_range(0, 1);
                switches[16*bank +: 16] = sw_vals[$urandom_range(0, 3)];
            end
            if ($urandom_range(0, 2) == 0) begin
                io_read = 1'b0; io_write = 1'b0;
            end else begin
                int ai;
                io_read = 1'($urandom_range(0, 1));
                io_write = !io_read || ($urandom_range(0, 9) == 0);
                ai = $urandom_range(0, 11);
                io_addr = (ai == 11) ? 8'($urandom) : (addrs[ai] | 8'($urandom_range(0, 3)));
                io_wdata = $urandom;
                if ((io_addr & 8'hFC) == 8'h84) io_wdata[23:0] = 24'($urandom_range(0, 5));
            end
            if (it == 300) begin
                #2 rst = 1'b0;
                @(posedge clock); #1;
                rst = 1'b1;
            end else begin
                @(posedge clock); #1;
            end
        end
        io_read = 1'b0; io_write = 1'b0;
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
